// File: rtl/ifu.sv
// Instruction fetch stage: one outstanding 32-bit read, stall buffering, redirect with stale-response drop.
// Optional IFU_PERF_CNT_EN adds fetch_cnt/drop_cnt performance counters.
module ifu #(
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ireq,
  output logic [63:0] iaddr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [63:0] pc,
  output logic        idu_valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0] fetch_cnt,
  output logic [63:0] drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [63:0] fetch_pc, fetch_pc_nxt, pend_pc, tgt, dlv_pc;
  logic [31:0] pend_instr, dlv_instr;
  logic        drop, drop_nxt;
  logic        deliver, latch, discard;

  assign tgt  = redirect_pc & ~64'h3;
  assign ireq = (state == FETCH);

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_nxt     = drop;
    deliver      = 1'b0;
    latch        = 1'b0;
    discard      = 1'b0;
    dlv_pc       = pend_pc;
    dlv_instr    = pend_instr;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (redirect_valid) fetch_pc_nxt = tgt;
      end
      FETCH: begin
        if (redirect_valid) begin
          fetch_pc_nxt = tgt;
          // the in-flight response belongs to the old path
          if (iresp_ok) begin
            discard  = 1'b1;
            drop_nxt = 1'b0;
          end else begin
            drop_nxt = 1'b1;
          end
        end else if (iresp_ok) begin
          if (drop) begin
            discard  = 1'b1;
            drop_nxt = 1'b0;
          end else begin
            fetch_pc_nxt = iaddr + 64'd4;
            if (stall) begin
              latch     = 1'b1;
              state_nxt = HOLD;
            end else begin
              deliver   = 1'b1;
              dlv_pc    = iaddr;
              dlv_instr = iresp_data;
            end
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          fetch_pc_nxt = tgt;
          discard      = 1'b1;
          state_nxt    = FETCH;
        end else if (!stall) begin
          deliver   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      drop       <= 1'b0;
      iaddr      <= RESET_PC;
      instr      <= NOP_INSTR;
      pc         <= 64'd0;
      idu_valid  <= 1'b0;
      pend_instr <= NOP_INSTR;
      pend_pc    <= 64'd0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      drop      <= drop_nxt;
      idu_valid <= deliver;
      // address is frozen only while a request is waiting for its response
      if (!(state == FETCH && !iresp_ok)) iaddr <= fetch_pc_nxt;
      if (deliver) begin
        instr <= dlv_instr;
        pc    <= dlv_pc;
      end else if (discard) begin
        instr <= NOP_INSTR;
      end
      if (latch) begin
        pend_instr <= iresp_data;
        pend_pc    <= iaddr;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= 64'd0;
      drop_cnt  <= 64'd0;
    end else begin
      if (deliver) fetch_cnt <= fetch_cnt + 64'd1;
      if (discard) drop_cnt  <= drop_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed table-driven bench for ifu: fetch, stall/hold, redirects, PC wrap, async reset.
module tb_ifu;
  localparam logic [63:0] R    = 64'h8000_0000;
  localparam logic [63:0] NOP  = 64'h0000_0013;
  localparam logic [63:0] Z    = 64'd0;
  localparam logic [63:0] TOP  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] D0   = 64'h0010_0093;
  localparam logic [63:0] D1   = 64'h0020_0113;
  localparam logic [63:0] D3   = 64'h0040_0213;
  localparam logic [63:0] D4   = 64'h0050_0293;
  localparam logic [63:0] D5   = 64'h0060_0313;
  localparam logic [63:0] D6   = 64'h0070_0393;
  localparam logic [63:0] DA   = 64'h00A0_0093;
  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ireq, iresp_ok, redirect_valid, stall, idu_valid;
  logic [63:0] iaddr, redirect_pc, pc;
  logic [31:0] iresp_data, instr;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  ifu dut (
    .clk(clk), .rst(rst), .ireq(ireq), .iaddr(iaddr),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .instr(instr), .pc(pc), .idu_valid(idu_valid)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    bit          ok;
    logic [31:0] data;
    bit          rv;
    logic [63:0] rpc;
    bit          stl;
    bit          e_ireq;
    logic [63:0] e_iaddr;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    bit          e_v;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit eq, input logic [63:0] ea,
                         input logic [63:0] ei, input logic [63:0] ep, input bit ev);
    chk({tag, " ireq"},      {63'd0, ireq},      {63'd0, eq});
    chk({tag, " iaddr"},     iaddr,              ea);
    chk({tag, " instr"},     {32'd0, instr},     ei);
    chk({tag, " pc"},        pc,                 ep);
    chk({tag, " idu_valid"}, {63'd0, idu_valid}, {63'd0, ev});
  endtask

  task automatic add(input bit ok, input logic [63:0] d, input bit rv, input logic [63:0] rpc,
                     input bit stl, input bit eq, input logic [63:0] ea, input logic [63:0] ei,
                     input logic [63:0] ep, input bit ev);
    vec_t v;
    v.ok = ok; v.data = d[31:0]; v.rv = rv; v.rpc = rpc; v.stl = stl;
    v.e_ireq = eq; v.e_iaddr = ea; v.e_instr = ei[31:0]; v.e_pc = ep; v.e_v = ev;
    tbl.push_back(v);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      iresp_ok       = tbl[i].ok;
      iresp_data     = tbl[i].data;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      stall          = tbl[i].stl;
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), tbl[i].e_ireq, tbl[i].e_iaddr,
              {32'd0, tbl[i].e_instr}, tbl[i].e_pc, tbl[i].e_v);
    end
    iresp_ok = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
  endtask

  initial begin
    iresp_ok = 1'b0; iresp_data = 32'd0; redirect_valid = 1'b0;
    redirect_pc = 64'd0; stall = 1'b0;

    // basic fetch, then redirect with an outstanding request
    add(N, Z, N, Z, N,        Y, R,          NOP, Z,          N); // 0 IDLE->FETCH
    add(Y, D0, N, Z, N,       Y, R + 4,      D0,  R,          Y); // 1
    add(N, Z, N, Z, N,        Y, R + 4,      D0,  R,          N); // 2
    add(Y, D1, N, Z, N,       Y, R + 8,      D1,  R + 4,      Y); // 3
    add(N, Z, Y, R + 'h100, N, Y, R + 8,     D1,  R + 4,      N); // 4 redirect, hold addr
    add(N, Z, N, Z, N,        Y, R + 8,      D1,  R + 4,      N); // 5
    add(Y, 64'hDEADBEEF, N, Z, N, Y, R + 'h100, NOP, R + 4,   N); // 6 stale dropped
    add(N, Z, N, Z, N,        Y, R + 'h100,  NOP, R + 4,      N); // 7
    add(Y, D3, N, Z, N,       Y, R + 'h104,  D3,  R + 'h100,  Y); // 8
    // stall into HOLD, release, redirects, wrap, redirect in HOLD
    add(N, Z, N, Z, N,        Y, R + 'h104,  D3,  R + 'h100,  N); // 9
    add(Y, DA, N, Z, Y,       N, R + 'h108,  D3,  R + 'h100,  N); // 10
    add(N, Z, N, Z, Y,        N, R + 'h108,  D3,  R + 'h100,  N); // 11
    add(N, Z, N, Z, Y,        N, R + 'h108,  D3,  R + 'h100,  N); // 12
    add(N, Z, N, Z, N,        Y, R + 'h108,  DA,  R + 'h104,  Y); // 13
    add(N, Z, N, Z, N,        Y, R + 'h108,  DA,  R + 'h104,  N); // 14
    add(Y, 64'h11111111, Y, R + 'h200, N, Y, R + 'h200, NOP, R + 'h104, N); // 15
    add(N, Z, N, Z, N,        Y, R + 'h200,  NOP, R + 'h104,  N); // 16
    add(Y, D4, N, Z, N,       Y, R + 'h204,  D4,  R + 'h200,  Y); // 17
    add(Y, 64'h22222222, Y, R + 'h102, N, Y, R + 'h100, NOP, R + 'h200, N); // 18
    add(N, Z, Y, TOP, N,      Y, R + 'h100,  NOP, R + 'h200,  N); // 19
    add(Y, 64'h33333333, N, Z, N, Y, TOP,    NOP, R + 'h200,  N); // 20
    add(N, Z, N, Z, N,        Y, TOP,        NOP, R + 'h200,  N); // 21
    add(Y, D5, N, Z, N,       Y, Z,          D5,  TOP,        Y); // 22 wrap
    add(N, Z, N, Z, N,        Y, Z,          D5,  TOP,        N); // 23
    add(Y, 64'h44444444, N, Z, Y, N, 64'd4,  D5,  TOP,        N); // 24
    add(N, Z, Y, R + 'h300, Y, Y, R + 'h300, NOP, TOP,        N); // 25
    add(Y, 64'h55555555, N, Z, Y, N, R + 'h304, NOP, TOP,     N); // 26

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", N, R, NOP, Z, N);
`ifdef IFU_PERF_CNT_EN
    chk("reset fetch_cnt", fetch_cnt, 64'd0);
    chk("reset drop_cnt",  drop_cnt,  64'd0);
`endif
    rst = 1'b1;

    apply(0, 9);
`ifdef IFU_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 64'd3);
    chk("drop_cnt",  drop_cnt,  64'd1);
`endif
    apply(9, tbl.size());

    // asynchronous reset while in HOLD
    #2 rst = 1'b0;
    #1 chk_out("async_rst", N, R, NOP, Z, N);
`ifdef IFU_PERF_CNT_EN
    chk("async_rst fetch_cnt", fetch_cnt, 64'd0);
    chk("async_rst drop_cnt",  drop_cnt,  64'd0);
`endif

    // late response in IDLE is ignored; redirect in IDLE needs no drop
    #3 rst = 1'b1;
    iresp_ok = 1'b1; iresp_data = 32'h6666_6666;
    redirect_valid = 1'b1; redirect_pc = R + 'h400;
    @(posedge clk); #1;
    chk_out("idle_resp", Y, R + 'h400, NOP, Z, N);
    iresp_ok = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    chk_out("idle_wait", Y, R + 'h400, NOP, Z, N);
    iresp_ok = 1'b1; iresp_data = D6[31:0];
    @(posedge clk); #1;
    chk_out("idle_fetch", Y, R + 'h404, D6, R + 'h400, Y);
    iresp_ok = 1'b0;
`ifdef IFU_PERF_CNT_EN
    chk("post fetch_cnt", fetch_cnt, 64'd1);
    chk("post drop_cnt",  drop_cnt,  64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
